// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and frame geometry.
package loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CSUM_W         = 8;
  localparam int unsigned LEN_W          = LEN_BYTES * BYTE_W;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR,
    ST_CHECK
  } state_e;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Assembles little-endian bytes into a 32-bit word.
//   clk, reset   : clock, async active-low reset
//   load         : shift byte_in into the word (first byte ends up in bits [7:0])
//   clear        : restart assembly at byte 0 with an all-zero word
//   byte_in      : incoming byte
//   word         : assembled word (registered)
//   word_full    : three bytes held, so the byte being loaded completes the word
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [BYTE_CNT_W-1:0] cnt_q;
  logic [WORD_W-1:0]     word_q;

  // Bytes enter at the top and move down, so after four loads byte 0 sits in [7:0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (load) begin
      cnt_q  <= cnt_q + BYTE_CNT_W'(1);
      word_q <= {byte_in, word_q[WORD_W-1:BYTE_W]};
    end
  end

  assign word      = word_q;
  assign word_full = (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a program image from a byte stream into the instruction memory write port,
// holding the core in reset while loading.
// Frame: LEN_LO, LEN_HI (word count N), then 4*N bytes, each word LSB first.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum byte
// (8-bit sum of all frame bytes must be zero) checked in a CHECK state.
// Ports:
//   clk, reset            : clock, async active-low reset
//   start_i               : begin a load (honoured in IDLE, DONE, ERROR)
//   byte_i/byte_valid_i   : stream input; byte_ready_o is the accept handshake
//   mem_we_o/addr/data    : one write strobe per assembled word
//   cpu_reset_n_o         : active-low core reset
//   busy_o/done_o/error_o : load status
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned                  MEMORY_DEPTH = 32,
  parameter int unsigned                  DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]        BASE_ADDR    = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [BYTE_W-1:0]     byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_reset_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      len_full;
  logic [DATA_WIDTH-1:0] addr_d;
  logic                  ready_d, we_d, cpu_rst_n_d, busy_d, done_d, error_d;
  logic                  fire;
  logic                  pk_load, pk_clear, pk_full;
  logic [WORD_W-1:0]     pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0]     csum_q, csum_d, csum_sum;
`endif

  assign fire     = byte_valid_i & byte_ready_o;
  assign len_full = {byte_i, len_q[BYTE_W-1:0]};

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .load      (pk_load),
    .clear     (pk_clear),
    .byte_in   (byte_i),
    .word      (pk_word),
    .word_full (pk_full)
  );

  // The packer's register is the data output; it is stable throughout WRITE.
  assign mem_data_o = DATA_WIDTH'(pk_word);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      byte_ready_o  <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= BASE_ADDR;
      cpu_reset_n_o <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      byte_ready_o  <= ready_d;
      mem_we_o      <= we_d;
      mem_addr_o    <= addr_d;
      cpu_reset_n_o <= cpu_rst_n_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      error_o       <= error_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running 8-bit sum of every accepted frame byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign csum_sum = csum_q + byte_i;
`endif

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    addr_d   = mem_addr_o;
    pk_load  = 1'b0;
    pk_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    if (fire && state_q != ST_CHECK) csum_d = csum_sum;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d  = ST_LEN_LO;
          idx_d    = '0;
          pk_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (fire) begin
          len_d   = LEN_W'(byte_i);
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (fire) begin
          len_d = len_full;
          if (len_full == '0 || 32'(len_full) > MEMORY_DEPTH) state_d = ST_ERROR;
          else                                                 state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fire) begin
          pk_load = 1'b1;
          if (pk_full) begin
            state_d = ST_WRITE;
            addr_d  = BASE_ADDR + (DATA_WIDTH'(idx_q) << 2);
          end
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if (LEN_W'(idx_q + IDX_W'(1)) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (fire) begin
          if (csum_sum == '0) state_d = ST_DONE;
          else                state_d = ST_ERROR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    ready_d     = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                  (state_d == ST_DATA)   || (state_d == ST_CHECK);
    we_d        = (state_d == ST_WRITE);
    busy_d      = ready_d || we_d;
    cpu_rst_n_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every write strobe.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_reset_n_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          post_pending = 0;
  logic [7:0]  tb_sum;
  logic [31:0] w4 [4];

  program_loader #(
    .MEMORY_DEPTH (32),
    .DATA_WIDTH   (32),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_ready_o  (byte_ready_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .cpu_reset_n_o (cpu_reset_n_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] data, input bit last);
    exp_t e;
    e.addr = BASE + 32'(idx) * 32'd4;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Present one byte and hold it until the handshake completes; optional idle gaps.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps && $urandom_range(0, 2) == 0) begin
      byte_valid_i = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    byte_i       = b;
    byte_valid_i = 1'b1;
    tb_sum       = tb_sum + b;
    t = 0;
    while (!byte_ready_o && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    if (!byte_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_ready_timeout: ready %b after %0d cycles, required 1", byte_ready_o, t);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_hdr(input logic [15:0] n, input bit gaps);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input bit last, input bit gaps);
    push_exp(idx, w, last);
    send_byte(w[7:0], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[31:24], gaps);
  endtask

  task automatic end_frame(input logic [7:0] offset);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'h00 - tb_sum + offset;
    send_byte(c, 1'b0);
`else
    if (offset != 8'h00) $display("note: checksum offset ignored in this build");
`endif
    byte_valid_i = 1'b0;
  endtask

  task automatic start_pulse();
    byte_valid_i = 1'b0;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    tb_sum  = 8'h00;
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_ready", 32'(byte_ready_o), 32'd1);
    check("start_cpu_rst", 32'(cpu_reset_n_o), 32'd0);
    check("start_clr", 32'({done_o, error_o}), 32'd0);
  endtask

  task automatic wait_end(input bit ok, input string tag);
    int t;
    byte_valid_i = 1'b0;
    t = 0;
    while (!(done_o || error_o) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_done"}, 32'(done_o), 32'(ok));
    check({tag, "_error"}, 32'(error_o), 32'(!ok));
    check({tag, "_cpu_rst"}, 32'(cpu_reset_n_o), 32'(ok));
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    check({tag, "_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_addr"}, mem_addr_o, BASE);
    check({tag, "_data"}, mem_data_o, 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_reset_n_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_error"}, 32'(error_o), 32'd0);
  endtask

  // Monitor: compares every write strobe against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (post_pending) begin
        post_pending = 0;
`ifdef LOADER_CHECKSUM_EN
        check("post_last_busy", 32'(busy_o), 32'd1);
        check("post_last_ready", 32'(byte_ready_o), 32'd1);
`else
        check("post_last_done", 32'(done_o), 32'd1);
        check("post_last_busy", 32'(busy_o), 32'd0);
        check("post_last_cpu_rst", 32'(cpu_reset_n_o), 32'd1);
`endif
      end
      if (mem_we_o) begin
        check("we_ready_low", 32'(byte_ready_o), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr_o, mem_data_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr_o, e.addr);
          check("wr_data", mem_data_o, e.data);
          if (e.last) post_pending = 1;
        end
      end
    end
  end

  initial begin : stim
    reset        = 1'b0;
    start_i      = 1'b0;
    byte_i       = 8'h00;
    byte_valid_i = 1'b0;
    tb_sum       = 8'h00;
    w4[0] = 32'hDEAD_BEEF;
    w4[1] = 32'h0123_4567;
    w4[2] = 32'h89AB_CDEF;
    w4[3] = 32'hFFFF_0001;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;
    @(posedge clk); #1;
    check("boot_cpu_rst", 32'(cpu_reset_n_o), 32'd1);
    check("boot_idle_ready", 32'(byte_ready_o), 32'd0);

    // Two-word image.
    start_pulse();
    send_hdr(16'd2, 1'b0);
    send_word(0, 32'h0000_0513, 1'b0, 1'b0);
    send_word(1, 32'h0015_0593, 1'b1, 1'b0);
    end_frame(8'h00);
    wait_end(1'b1, "n2");

    // Illegal word counts.
    start_pulse();
    send_hdr(16'd0, 1'b0);
    wait_end(1'b0, "n0");
    start_pulse();
    send_hdr(16'd33, 1'b0);
    wait_end(1'b0, "n33");
    start_pulse();
    send_hdr(16'h0100, 1'b0);
    wait_end(1'b0, "n256");

    // Full-depth image, last address BASE + 0x7C.
    start_pulse();
    send_hdr(16'd32, 1'b0);
    for (int i = 0; i < 32; i++)
      send_word(i, 32'hC0DE_0000 + 32'(i) * 32'h0000_0101, i == 31, 1'b0);
    end_frame(8'h00);
    wait_end(1'b1, "n32");

    // Four words with random gaps in byte_valid_i.
    start_pulse();
    send_hdr(16'd4, 1'b1);
    for (int i = 0; i < 4; i++) send_word(i, w4[i], i == 3, 1'b1);
    end_frame(8'h00);
    wait_end(1'b1, "gaps");

    // start_i in the middle of a word must be ignored.
    start_pulse();
    send_hdr(16'd2, 1'b0);
    send_word(0, 32'hA5A5_5A5A, 1'b0, 1'b0);
    push_exp(1, 32'h4433_2211, 1'b1);
    send_byte(8'h11, 1'b0);
    byte_valid_i = 1'b0;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    end_frame(8'h00);
    wait_end(1'b1, "start_mid");

    // Reset after five data bytes, then a clean reload.
    start_pulse();
    send_hdr(16'd2, 1'b0);
    send_word(0, 32'h0403_0201, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0);
    reset        = 1'b0;
    byte_valid_i = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    start_pulse();
    send_hdr(16'd2, 1'b0);
    send_word(0, 32'h0000_0513, 1'b0, 1'b0);
    send_word(1, 32'h0015_0593, 1'b1, 1'b0);
    end_frame(8'h00);
    wait_end(1'b1, "reload");

`ifdef LOADER_CHECKSUM_EN
    // Checksum off by one.
    start_pulse();
    send_hdr(16'd1, 1'b0);
    send_word(0, 32'h1234_5678, 1'b1, 1'b0);
    end_frame(8'h01);
    wait_end(1'b0, "csum_bad");
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image into the instruction ROM from a byte stream, instead of relying only on the boot-time file image. It sits between a byte source (UART receiver or debug link) and the write port of the program memory. It holds the core in reset while loading and releases it once the image is complete. It packs little-endian bytes into 32-bit words and issues one memory write per word, at the same byte addresses the core fetches from.

## Interface
- MEMORY_DEPTH, 32, instruction memory depth in words; maximum loadable word count
- DATA_WIDTH, 32, width of the instruction word and the address bus
- BASE_ADDR, 32'h0040_0000, byte address of word 0; the memory decodes word index from address bits [16:2]
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start_i  input  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERROR
- byte_i  input  8  stream data byte
- byte_valid_i  input  1  byte_i is valid
- byte_ready_o  output  1  loader accepts a byte this cycle
- mem_we_o  output  1  single-cycle write strobe to program memory
- mem_addr_o  output  DATA_WIDTH  byte address of the word being written
- mem_data_o  output  DATA_WIDTH  assembled instruction word
- cpu_reset_n_o  output  1  active-low core reset; low while a load is in progress or has failed
- busy_o  output  1  load in progress
- done_o  output  1  last load completed successfully; held until the next start_i
- error_o  output  1  last load failed; held until the next start_i

## Operation
- Handshake: a byte is consumed on a rising edge where byte_valid_i and byte_ready_o are both 1. byte_valid_i may be held across cycles.
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes, each word least-significant byte first.
- States:
  - IDLE: no bytes accepted. start_i -> LEN_LO.
  - LEN_LO: accept the low count byte -> LEN_HI.
  - LEN_HI: accept the high count byte. If N == 0 or N > MEMORY_DEPTH -> ERROR, otherwise -> DATA.
  - DATA: accept bytes. On the 4th byte of a word -> WRITE.
  - WRITE: mem_we_o=1 for one cycle with mem_addr_o = BASE_ADDR + 4·word_index and mem_data_o = the assembled word; word_index then increments. If this was word N-1 -> DONE (or CHECK when configured), else -> DATA.
  - DONE: done_o=1, cpu_reset_n_o=1. start_i -> LEN_LO.
  - ERROR: error_o=1, cpu_reset_n_o=0. start_i -> LEN_LO.
- byte_ready_o=1 only in LEN_LO, LEN_HI, DATA and CHECK. It is 0 in WRITE, which stalls the stream for one cycle per word.
- On start_i: word_index, byte counter and checksum clear; done_o and error_o clear; cpu_reset_n_o goes to 0.
- Word index arithmetic uses log2(MEMORY_DEPTH)+1 bits; the address is computed at full DATA_WIDTH with no wrap.
- start_i arriving during LEN_LO..WRITE (or CHECK) is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - byte_ready_o 0, mem_we_o 0, mem_addr_o BASE_ADDR, mem_data_o 0
  - cpu_reset_n_o 0, busy_o 0, done_o 0, error_o 0
- After reset, in IDLE, cpu_reset_n_o rises on the first clock edge so the core runs the boot-time image.
- start_i at edge k: busy_o=1 and byte_ready_o=1 from cycle k+1.
- 4th byte of a word accepted at edge k: mem_we_o=1 during cycle k+1; byte_ready_o returns to 1 in cycle k+2.
- Final write: done_o=1, busy_o=0 and cpu_reset_n_o=1 one cycle after the write cycle.
- Reset asserted mid-load: immediate return to reset values. Memory contents are partial and undefined; no write strobe is produced during reset.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last WRITE the FSM enters CHECK and accepts one extra byte.
  - The 8-bit sum of both length bytes, all data bytes and this byte must be 0 mod 256 -> DONE, otherwise -> ERROR.
  - Words are already written on failure; cpu_reset_n_o stays 0.
- Not defined: there is no CHECK state and no checksum logic; the last WRITE goes directly to DONE.

## Structure
- Shared package loader_pkg:
  - state encoding enum
  - LEN_BYTES = 2
  - BYTES_PER_WORD = 4
  - checksum width of 8
- Sub-module byte_packer: 2-bit byte counter plus a 32-bit shift register, with inputs load/clear and outputs word and word_full. The FSM instantiates it once.

## Test plan
- Load N=2, bytes 13 05 00 00 / 93 05 15 00 -> writes 0x00000513 at 0x00400000 and 0x00150593 at 0x00400004; done_o=1; cpu_reset_n_o rises one cycle after the 2nd write.
- Send header N=0, then N=33 with MEMORY_DEPTH=32 -> ERROR after LEN_HI; no mem_we_o pulses; cpu_reset_n_o stays 0.
- Toggle byte_valid_i randomly during a 4-word load -> exactly 4 write strobes, correct data, none lost or duplicated; byte_ready_o=0 in every WRITE cycle.
- Pulse start_i during DATA -> ignored; the load completes normally.
- Assert reset after 5 data bytes -> all outputs at reset values immediately; a subsequent full load succeeds from word 0.
- With LOADER_CHECKSUM_EN: correct checksum byte -> done_o=1; checksum off by 1 -> error_o=1 and cpu_reset_n_o=0.
